// File: rtl/input_mod.sv
// Operator input port: waits for a debounced button press while the CPU requests input,
// then captures the switches as a 32-bit word. Optional macro INPUT_SIGN_EXT_EN sign-extends the capture.
module input_mod #(
  parameter int unsigned      CNT_W           = 16,
  parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = CNT_W'(4),
  parameter int unsigned      SW_W            = 17
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req,
  input  logic            button,
  input  logic [SW_W-1:0] switches,
  output logic [31:0]     data,
  output logic            valid,
  output logic            busy,
  output logic            pressed
);

  localparam int unsigned DATA_W = 32;
  localparam logic [CNT_W-1:0] CntMax = DEBOUNCE_CYCLES - CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    WAIT_RELEASE
  } state_e;

  state_e             state_q;
  logic               sync1_q;
  logic               sync2_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               pressed_q;
  logic               pressed_d;
  logic               pressed_dly_q;
  logic               rise_c;
  logic [DATA_W-1:0]  data_q;
  logic [DATA_W-1:0]  capture_c;
  logic               valid_q;
  logic               busy_q;

  // Two-flop synchronizer; released level (1) out of reset
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= button;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: pressed only flips after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_comb begin
    cnt_d     = cnt_q;
    pressed_d = pressed_q;
    if ((!sync2_q) == pressed_q) begin
      cnt_d = '0;
    end else if (cnt_q >= CntMax) begin
      pressed_d = ~pressed_q;
      cnt_d     = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q         <= '0;
      pressed_q     <= 1'b0;
      pressed_dly_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      pressed_q     <= pressed_d;
      pressed_dly_q <= pressed_q;
    end
  end

  assign rise_c = pressed_q & ~pressed_dly_q;

`ifdef INPUT_SIGN_EXT_EN
  assign capture_c = DATA_W'($signed(switches));
`else
  assign capture_c = DATA_W'(switches);
`endif

  // Request FSM; abort on req drop takes priority over a coincident press edge
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req) begin
            state_q <= WAIT_PRESS;
            busy_q  <= 1'b1;
          end
        end
        WAIT_PRESS: begin
          if (!req) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (rise_c) begin
            data_q  <= capture_c;
            valid_q <= 1'b1;
            state_q <= WAIT_RELEASE;
          end
        end
        WAIT_RELEASE: begin
          if (!pressed_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data    = data_q;
  assign valid   = valid_q;
  assign busy    = busy_q;
  assign pressed = pressed_q;

endmodule

// File: tb/tb_input_mod.sv
// Scoreboard bench for input_mod: expected captures (data + arrival cycle) are queued by
// the stimulus and popped by a monitor whenever valid is seen.
module tb_input_mod;

  localparam int unsigned DEB  = 4;
  localparam int unsigned SW_W = 17;
  localparam int unsigned LAT  = DEB + 3;

  typedef struct {
    logic [31:0] data;
    int unsigned cyc;
  } exp_t;

  logic            clock;
  logic            reset;
  logic            req;
  logic            button;
  logic [SW_W-1:0] switches;
  logic [31:0]     data;
  logic            valid;
  logic            busy;
  logic            pressed;

  exp_t        sb_q[$];
  int unsigned cycle_cnt;
  int          vectors;
  int          miscompares;

  input_mod #(
    .CNT_W          (16),
    .DEBOUNCE_CYCLES(16'(DEB)),
    .SW_W           (SW_W)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .button  (button),
    .switches(switches),
    .data    (data),
    .valid   (valid),
    .busy    (busy),
    .pressed (pressed)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cycle_cnt = 0;
  always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle_cnt);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Press the button; optionally queue the capture expected LAT cycles later
  task automatic press(input bit expect_cap, input logic [31:0] exp_data);
    button = 1'b0;
    if (expect_cap) sb_q.push_back('{data: exp_data, cyc: cycle_cnt + LAT});
  endtask

  // Monitor: every valid must match the head of the scoreboard, in data and timing
  always @(negedge clock) begin
    if (valid === 1'b1) begin
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_valid: got data %h expected no valid (cycle %0d)", data, cycle_cnt);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if (data !== e.data || cycle_cnt != e.cyc) begin
          miscompares++;
          $display("FAIL capture: got data %h at cycle %0d expected %h at cycle %0d",
                   data, cycle_cnt, e.data, e.cyc);
        end
      end
    end
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset    = 1'b0;
    req      = 1'b0;
    button   = 1'b0;
    switches = 17'h1FFFF;

    // Reset with button held and switches all ones
    step(2);
    check("rst_data", data, 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_pressed", 32'(pressed), 32'h0);
    button = 1'b1;
    reset  = 1'b1;
    step(3);
    check("idle_busy", 32'(busy), 32'h0);

    // Basic capture with exact latency, then release with req dropped
    switches = 17'h00ABC;
    req      = 1'b1;
    step(1);
    check("req_busy", 32'(busy), 32'h1);
    press(1'b1, 32'h0000_0ABC);
    step(LAT + 1);
    check("cap_data", data, 32'h0000_0ABC);
    check("cap_busy", 32'(busy), 32'h1);
    button = 1'b1;
    req    = 1'b0;
    step(5);
    check("rel_pressed_hold", 32'(pressed), 32'h1);
    step(1);
    check("rel_pressed_fall", 32'(pressed), 32'h0);
    check("rel_busy_hold", 32'(busy), 32'h1);
    step(1);
    check("rel_busy_fall", 32'(busy), 32'h0);
    check("sb_basic", sb_q.size(), 0);

    // Bounce rejection
    req = 1'b1;
    step(1);
    for (int i = 0; i < 10; i++) begin
      button = (i % 2 == 0) ? 1'b0 : 1'b1;
      step(1);
      check("bounce_pressed", 32'(pressed), 32'h0);
    end
    step(8);
    check("bounce_pressed_end", 32'(pressed), 32'h0);
    check("bounce_busy", 32'(busy), 32'h1);
    check("sb_bounce", sb_q.size(), 0);

    // Plain abort before any press
    req = 1'b0;
    step(2);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_data", data, 32'h0000_0ABC);

    // Held before request: first press ignored, second press captured
    button = 1'b0;
    step(8);
    check("held_pressed", 32'(pressed), 32'h1);
    switches = 17'h01234;
    req      = 1'b1;
    step(10);
    check("held_busy", 32'(busy), 32'h1);
    check("held_data", data, 32'h0000_0ABC);
    button = 1'b1;
    step(8);
    check("held_rel_pressed", 32'(pressed), 32'h0);
    check("held_rel_busy", 32'(busy), 32'h1);
    switches = 17'h05A5A;
    press(1'b1, 32'h0000_5A5A);
    step(LAT + 1);
    check("held_cap_data", data, 32'h0000_5A5A);
    button = 1'b1;
    req    = 1'b0;
    step(8);
    check("held_end_busy", 32'(busy), 32'h0);

    // Abort coinciding with the press edge
    switches = 17'h1F0F0;
    req      = 1'b1;
    step(2);
    press(1'b0, 32'h0);
    step(5);
    check("race_pressed_pre", 32'(pressed), 32'h0);
    step(1);
    check("race_pressed_rise", 32'(pressed), 32'h1);
    req = 1'b0;
    step(1);
    check("race_busy", 32'(busy), 32'h0);
    check("race_data", data, 32'h0000_5A5A);
    button = 1'b1;
    step(8);
    check("sb_race", sb_q.size(), 0);

    // Sign-extension capture; req held through release restarts a request
    switches = 17'h10001;
    req      = 1'b1;
    step(2);
`ifdef INPUT_SIGN_EXT_EN
    press(1'b1, 32'hFFFF_0001);
`else
    press(1'b1, 32'h0001_0001);
`endif
    step(LAT + 1);
    button = 1'b1;
    step(7);
    check("rehold_busy_idle", 32'(busy), 32'h0);
    step(1);
    check("rehold_busy_again", 32'(busy), 32'h1);
    req = 1'b0;
    step(2);
    check("sb_sext", sb_q.size(), 0);

    // Reset arriving on the capture edge drops the pending valid
    switches = 17'h00777;
    req      = 1'b1;
    step(2);
    press(1'b0, 32'h0);
    step(6);
    reset = 1'b0;
    step(1);
    check("mid_rst_valid", 32'(valid), 32'h0);
    check("mid_rst_data", data, 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_pressed", 32'(pressed), 32'h0);
    button = 1'b1;
    req    = 1'b0;
    reset  = 1'b1;
    step(4);
    check("sb_final", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/input_mod.md
Name: input_mod

Overview:
- Input-side counterpart of the 7-segment output path. Serves the CPU's input instruction: when the controller requests input, the block waits for an operator button press, then captures the 17 switches into a 32-bit word.
- Delivers the word with a one-cycle valid pulse for the register-write mux, and holds busy so the program counter stalls until the value is delivered.
- Sits between the board (button, switches) and the CPU core. Clocked by the divided CPU clock.

Parameters:
- DEBOUNCE_CYCLES, 16'd4, consecutive stable cycles required before the debounced button level changes (must be >= 1).
- CNT_W, 16, width of the debounce counter.
- SW_W, 17, switch bus width (must be <= 32).

Ports:
- clock  input  1  CPU clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset.
- req  input  1  input request from the controller, level-sensitive; held high while the input instruction executes.
- button  input  1  raw board pushbutton, active-low (0 = pressed), asynchronous to clock.
- switches  input  SW_W  raw switch levels, sampled only at capture.
- data  output  32  captured switch word.
- valid  output  1  one-cycle pulse; data is new this cycle.
- busy  output  1  high while a request is pending or the button release is awaited.
- pressed  output  1  debounced button level (1 = pressed), for display/debug.

Behaviour:
- Reset (reset==0 at a clock edge) forces: state=IDLE, data=0, valid=0, busy=0, pressed=0, debounce counter=0, both synchronizer flops=1 (released).
- Synchronizer: two flops on button; s2 is the synchronized raw level.
- Debounce:
  - If ~s2 == pressed, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, pressed toggles and the counter clears.
  - The counter never wraps. A bounce shorter than DEBOUNCE_CYCLES leaves pressed unchanged.
- Press edge: rise = pressed & ~pressed_q, where pressed_q is pressed delayed one cycle.
- FSM, 3 states, registered outputs:
  - IDLE: busy=0. If req=1, go to WAIT_PRESS and set busy=1 in the same edge.
  - WAIT_PRESS: busy=1.
    - If req=0, go to IDLE with busy=0 (abort; data unchanged, no valid).
    - Else if rise=1: data <= {zero-extend(switches)}, valid <= 1, go to WAIT_RELEASE.
  - WAIT_RELEASE: valid returns to 0 after exactly one cycle; busy stays 1. When pressed=0, go to IDLE and set busy=0. req is ignored in this state.
- Capture timing:
  - A button already held when WAIT_PRESS is entered does not count. A fresh rise is required (release, then press).
  - A rise that occurs while in IDLE is discarded.
- Latency: a clean raw press that is stable from cycle t produces valid high at cycle t+DEBOUNCE_CYCLES+3 (2 sync + DEBOUNCE_CYCLES debounce + 1 edge/capture), provided the FSM is already in WAIT_PRESS.
- Simultaneous events:
  - req falling in the same cycle as rise: abort wins (no capture).
  - req=1 held through WAIT_RELEASE into IDLE starts a new request on the next edge.
- Reset mid-operation: reset returns every register to its reset value on that edge regardless of state. A pending valid is dropped.
- data holds its last captured value indefinitely, and between captures.

Optional Feature:
- Macro INPUT_SIGN_EXT_EN.
- When defined, capture sign-extends: data[31:SW_W] = switches[SW_W-1].
- When undefined, data[31:SW_W] = 0.
- All other behaviour is identical.

Test Plan:
- Reset: hold reset=0 for 2 cycles with button=0 and switches=17'h1FFFF -> data=0, valid=0, busy=0, pressed=0.
- Basic capture (DEBOUNCE_CYCLES=4): switches=17'h00ABC, req=1, then button=0 stable from cycle t -> valid=1 for exactly 1 cycle at t+7, data=32'h00000ABC, busy=1 until pressed falls after release, then busy=0.
- Bounce rejection: toggle button at 1-cycle intervals for 10 cycles, then hold released -> pressed stays 0, no valid, busy stays 1.
- Held-before-request: button pressed and debounced, then req=1 -> no valid until the button is released and pressed again; data captured at the second press.
- Abort: req=1, drop req to 0 before any press; also drop req in the same cycle as rise -> busy=0, no valid, data keeps its previous value (e.g. 32'h00000ABC).
- Sign extension: with INPUT_SIGN_EXT_EN, switches=17'h10001 captured -> data=32'hFFFF0001. Without the macro -> data=32'h00010001.
